// File: rtl/alu_pkg.sv
// alu_pkg: funct3 encodings and FSM state encoding for alu_pipe
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SR = 3'd5;
  localparam logic [2:0] ALU_OR = 3'd6;
  localparam logic [2:0] ALU_AND = 3'd7;
  localparam logic [2:0] ALU_MUL = 3'd0;
  localparam logic [2:0] ALU_MULH = 3'd1;
  localparam logic [2:0] ALU_MULHSU = 3'd2;
  localparam logic [2:0] ALU_MULHU = 3'd3;
  localparam logic [2:0] ALU_DIV = 3'd4;
  localparam logic [2:0] ALU_DIVU = 3'd5;
  localparam logic [2:0] ALU_REM = 3'd6;
  localparam logic [2:0] ALU_REMU = 3'd7;
  typedef enum logic {ST_IDLE, ST_DIV} state_t;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: radix-2 restoring divider, one quotient bit per cycle, signed via magnitudes
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [XLEN-1:0] x,
  input logic [XLEN-1:0] y,
  input logic sgn,
  input logic want_rem,
  output logic done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic busy, neg_q, neg_r, rem_sel, sx, sy;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [XLEN:0] diff;
  assign sx = sgn & x[XLEN-1];
  assign sy = sgn & y[XLEN-1];
  assign diff = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign rem_n = diff[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : diff[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ~diff[XLEN]};
  assign done = busy & (&cnt);
  assign result = rem_sel ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem_sel <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= sx ? -x : x;
      dvs <= sy ? -y : y;
      neg_q <= sx ^ sy;
      neg_r <= sx;
      rem_sel <= want_rem;
    end else if (busy) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
      busy <= ~done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked integer ALU with registered output; ALU_MULDIV_EN adds MUL/DIV/REM
module alu_pipe #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [2:0] funct,
  input logic alt,
  input logic muldiv,
  input logic [XLEN-1:0] x,
  input logic [XLEN-1:0] y,
  output logic out_valid,
  input logic out_ready,
  output logic [XLEN-1:0] out
);
  import alu_pkg::*;
  localparam int SHAMT_W = $clog2(XLEN);
  state_t state;
  logic acc, start, div_done;
  logic [XLEN-1:0] base, res, div_res;
  logic signed [XLEN-1:0] sra;
  logic [SHAMT_W-1:0] shamt;
  assign shamt = y[SHAMT_W-1:0];
  assign sra = $signed(x) >>> shamt;
  assign in_ready = ~rst & (state == ST_IDLE) & (~out_valid | out_ready);
  assign acc = in_valid & in_ready;
  always_comb begin
    base = x & y;
    case (funct)
      ALU_ADD: base = alt ? x - y : x + y;
      ALU_SLL: base = x << shamt;
      ALU_SLT: base = {{XLEN-1{1'b0}}, $signed(x) < $signed(y)};
      ALU_SLTU: base = {{XLEN-1{1'b0}}, x < y};
      ALU_XOR: base = x ^ y;
      ALU_SR: base = alt ? sra : x >> shamt;
      ALU_OR: base = x | y;
      default: base = x & y;
    endcase
  end
`ifdef ALU_MULDIV_EN
  logic xs, ys, dz, ovf;
  logic signed [XLEN:0] ma, mb;
  logic signed [2*XLEN+1:0] prod;
  logic [1:0] prod_unused;
  logic [XLEN-1:0] mres, sres;
  assign xs = (funct == ALU_MULH || funct == ALU_MULHSU) & x[XLEN-1];
  assign ys = (funct == ALU_MULH) & y[XLEN-1];
  assign ma = {xs, x};
  assign mb = {ys, y};
  assign prod = ma * mb;
  assign prod_unused = prod[2*XLEN+1:2*XLEN];
  assign mres = funct == ALU_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign dz = y == '0;
  assign ovf = ~funct[0] & (x == {1'b1, {XLEN-1{1'b0}}}) & (&y);
  assign sres = dz ? (funct[1] ? x : '1) : (funct[1] ? '0 : x);
  assign start = acc & muldiv & funct[2] & ~dz & ~ovf;
  assign res = muldiv ? (funct[2] ? sres : mres) : base;
  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .start(start),
    .x(x),
    .y(y),
    .sgn(~funct[0]),
    .want_rem(funct[1]),
    .done(div_done),
    .result(div_res)
  );
`else
  logic muldiv_unused;
  assign muldiv_unused = muldiv;
  assign start = 1'b0;
  assign div_done = 1'b0;
  assign div_res = '0;
  assign res = base;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      out_valid <= 1'b0;
      out <= '0;
    end else begin
      if (div_done) begin
        out <= div_res;
        out_valid <= 1'b1;
      end else if (acc && !start) begin
        out <= res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      state <= start ? ST_DIV : div_done ? ST_IDLE : state;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (XLEN=32), MUL/DIV checks under ALU_MULDIV_EN
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic alt = 1'b0;
  logic muldiv = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [2:0] funct = 3'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] out;
  logic [31:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  alu_pipe #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .funct(funct),
    .alt(alt),
    .muldiv(muldiv),
    .x(x),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic md, input logic [2:0] f, input logic al,
                                        input logic [31:0] xa, input logic [31:0] yb);
    logic [63:0] p;
    logic ovf;
    ovf = (xa == 32'h8000_0000) && (yb == 32'hFFFF_FFFF);
    if (md) begin
      case (f)
        3'd0: return xa * yb;
        3'd1: p = {{32{xa[31]}}, xa} * {{32{yb[31]}}, yb};
        3'd2: p = {{32{xa[31]}}, xa} * {32'd0, yb};
        3'd3: p = {32'd0, xa} * {32'd0, yb};
        3'd4: return yb == 0 ? 32'hFFFF_FFFF : ovf ? xa : $signed(xa) / $signed(yb);
        3'd5: return yb == 0 ? 32'hFFFF_FFFF : xa / yb;
        3'd6: return yb == 0 ? xa : ovf ? 32'd0 : $signed(xa) % $signed(yb);
        default: return yb == 0 ? xa : xa % yb;
      endcase
      return p[63:32];
    end
    case (f)
      3'd0: return al ? xa - yb : xa + yb;
      3'd1: return xa << yb[4:0];
      3'd2: return {31'd0, $signed(xa) < $signed(yb)};
      3'd3: return {31'd0, xa < yb};
      3'd4: return xa ^ yb;
      3'd5: begin
        if (al) return $signed(xa) >>> yb[4:0];
        return xa >> yb[4:0];
      end
      3'd6: return xa | yb;
      default: return xa & yb;
    endcase
  endfunction
  task automatic send(input logic md, input logic [2:0] f, input logic al,
                      input logic [31:0] xa, input logic [31:0] yb, output int waited);
    muldiv = md;
    funct = f;
    alt = al;
    x = xa;
    y = yb;
    in_valid = 1'b1;
    for (waited = 0; waited < 200; waited++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    chk("accept", in_ready, 1'b1);
    if (in_ready) q.push_back(model(md, f, al, xa, yb));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      chk("sb_pending", q.size() > 0, 1'b1);
      if (q.size() > 0) chk("result", out, q.pop_front());
    end
  initial begin
    int w, k;
    logic bad;
    logic [31:0] ops[6];
    ops = '{32'h1234_5678, 32'h0000_0007, 32'h8765_4321, 32'hFFFF_FFE3, $urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, 32'd0);
    chk("rst_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(1'b0, ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, w);
    chk("add_lat", out_valid, 1'b1);
    chk("add_wrap", out, 32'd0);
    send(1'b0, ALU_SR, 1'b1, 32'h8000_0000, 32'h0000_0021, w);
    chk("sra", out, 32'hC000_0000);
    send(1'b0, ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, w);
    chk("slt", out, 32'd1);
    send(1'b0, ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, w);
    chk("sltu", out, 32'd0);
    for (int f = 0; f < 8; f++)
      for (int a = 0; a < 2; a++)
        for (int i = 0; i < 3; i++) begin
          send(1'b0, 3'(f), 1'(a), ops[2*i], ops[2*i+1], w);
          chk("b2b", w, 0);
        end
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(1'b0, ALU_ADD, 1'b1, 32'd10, 32'd3, w);
    funct = ALU_XOR;
    alt = 1'b0;
    x = 32'h0000_F0F0;
    y = 32'h0000_0FF0;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("hold_out", out, 32'd7);
      chk("hold_valid", out_valid, 1'b1);
      chk("full_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0, ALU_XOR, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, w);
    chk("pop_push", w, 0);
    chk("no_bubble_v", out_valid, 1'b1);
    chk("no_bubble", out, 32'h0000_FF00);
`ifdef ALU_MULDIV_EN
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, ALU_DIV, 1'b0, -32'sd7, 32'd2, w);
    bad = 1'b0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      bad |= in_ready;
    end
    chk("div_lat", k, 33);
    chk("div_busy", bad, 1'b0);
    chk("div_val", out, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    send(1'b1, ALU_REM, 1'b0, -32'sd7, 32'd2, w);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("rem_val", out, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    send(1'b1, ALU_DIVU, 1'b0, 32'd123, 32'd0, w);
    chk("dz_lat", out_valid, 1'b1);
    chk("dz_val", out, 32'hFFFF_FFFF);
    send(1'b1, ALU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, w);
    chk("ovf_q", out, 32'h8000_0000);
    send(1'b1, ALU_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, w);
    chk("ovf_r", out, 32'd0);
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 3; i++) begin
        send(1'b1, 3'(f), 1'b0, ops[2*i], ops[2*i+1], w);
        for (k = 1; k <= 100; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        chk("md_lat", k, f >= 4 ? 33 : 1);
        @(posedge clk);
        #1;
      end
    send(1'b1, ALU_DIVU, 1'b0, 32'd100, 32'd7, w);
    repeat (5) @(posedge clk);
    #1;
`else
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(1'b0, ALU_OR, 1'b0, 32'd1, 32'd2, w);
`endif
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("rst_mid_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_idle", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(1'b0, ALU_ADD, 1'b0, 32'd2, 32'd3, w);
    chk("post_rst_add", out, 32'd5);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("no_stale", out_valid, 1'b0);
    chk("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
